// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan position, visible-pixel flag, active-low syncs, line/frame strobes and frame counter.
// Optional macro VGA_SYNC_ALIGN_EN delays hs/vs by one clock to line them up with registered renderer RGB.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 1) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must lie within the 10-bit counter range");
        end
    endgenerate

    // Thresholds are 11 bits wide so a sync window ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_reg, x_next;
    logic [9:0] y_reg, y_next;
    logic       run_reg;
    logic       blank_reg, blank_next;
    logic       hs_reg, hs_next;
    logic       vs_reg, vs_next;
    logic       line_start_reg, line_start_next;
    logic       frame_start_reg, frame_start_next;
    logic [7:0] frame_count_reg, frame_count_next;
    logic [10:0] x_ext_next, y_ext_next;

    // run_reg is clear only on the first edge after reset, which presents (0,0) instead of advancing,
    // so every output is computed from the next position and stays registered.
    always_comb begin
        x_next           = '0;
        y_next           = '0;
        if (run_reg) begin
            if ({1'b0, x_reg} == H_LAST) begin
                x_next = '0;
                if ({1'b0, y_reg} == V_LAST) begin
                    y_next = '0;
                end else begin
                    y_next = y_reg + 10'd1;
                end
            end else begin
                x_next = x_reg + 10'd1;
                y_next = y_reg;
            end
        end

        x_ext_next       = {1'b0, x_next};
        y_ext_next       = {1'b0, y_next};
        blank_next       = (x_ext_next < H_VIS) && (y_ext_next < V_VIS);
        hs_next          = !((x_ext_next >= HS_START) && (x_ext_next < HS_END));
        vs_next          = !((y_ext_next >= VS_START) && (y_ext_next < VS_END));
        line_start_next  = (x_next == 10'd0);
        frame_start_next = (x_next == 10'd0) && (y_next == 10'd0);

        frame_count_next = frame_count_reg;
        if (frame_start_next && run_reg) begin
            frame_count_next = frame_count_reg + 8'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_reg           <= '0;
            y_reg           <= '0;
            run_reg         <= 1'b0;
            blank_reg       <= 1'b0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            run_reg         <= 1'b1;
            blank_reg       <= blank_next;
            hs_reg          <= hs_next;
            vs_reg          <= vs_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
            frame_count_reg <= frame_count_next;
        end
    end

    assign DrawX       = x_reg;
    assign DrawY       = y_reg;
    assign blank       = blank_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign frame_count = frame_count_reg;

`ifdef VGA_SYNC_ALIGN_EN
    logic hs_dly_reg;
    logic vs_dly_reg;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly_reg <= 1'b1;
            vs_dly_reg <= 1'b1;
        end else begin
            hs_dly_reg <= hs_reg;
            vs_dly_reg <= vs_reg;
        end
    end

    assign hs = hs_dly_reg;
    assign vs = vs_dly_reg;
`else
    assign hs = hs_reg;
    assign vs = vs_reg;
`endif

endmodule
